// File: rtl/rj_tx_lane_ctrl.sv
// RJ transmit lane controller: round-robin arbitration between requesters, then
// MSB-first serialization on lane[0] with a forwarded, programmable clock on lane[1].
module rj_tx_lane_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [CNT_W-1:0]          clk_l_cyc,
    input  logic [CNT_W-1:0]          clk_h_cyc,
    output logic [1:0]                rj_lane_o,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    logic [1:0]        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_q;
    logic [BIT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  l_q;
    logic [CNT_W-1:0]  h_q;
    logic [DATA_W-1:0] shreg;
    logic [1:0]        lane;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [DATA_W-1:0] win_data;
    logic [ID_W-1:0]   ptr_nxt;
    logic [CNT_W-1:0]  l_eff;
    logic [CNT_W-1:0]  h_eff;
    logic              grant;
    int                idx;

    // Search starts at the pointer and wraps, so the last winner gets lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
                win_data  = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    // Reset is folded in so no grant is advertised while the block is held in reset.
    assign grant   = rst_n && (state == IDLE) && enable && win_found;
    assign ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign l_eff   = (clk_l_cyc == '0) ? CNT_W'(1) : clk_l_cyc;
    assign h_eff   = (clk_h_cyc == '0) ? CNT_W'(1) : clk_h_cyc;

    always_comb begin
        gnt = '0;
        if (grant) gnt[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            bit_idx <= '0;
            cnt     <= '0;
            l_q     <= '0;
            h_q     <= '0;
            shreg   <= '0;
            lane    <= 2'b00;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        shreg   <= win_data;
                        id_q    <= win_idx;
                        l_q     <= l_eff;
                        h_q     <= h_eff;
                        cnt     <= l_eff - 1'b1;
                        ptr     <= ptr_nxt;
                        bit_idx <= BIT_W'(DATA_W - 1);
                        lane    <= {1'b0, win_data[DATA_W-1]};
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (cnt == '0) begin
                        cnt     <= h_q - 1'b1;
                        lane[1] <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - 1'b1;
                            cnt     <= l_q - 1'b1;
                            lane    <= {1'b0, shreg[bit_idx - 1'b1]};
                            state   <= LOW;
                        end else begin
                            lane    <= 2'b00;
                            done    <= 1'b1;
                            done_id <= id_q;
                            state   <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign rj_lane_o = lane;

endmodule
